prog_loader: RTL
================

# prog_loader

Program loader that fills instruction memory from a byte stream, mirroring the processor's ROM read path. It receives bytes from a serial receiver, frames them as `[word count][32-bit instructions]`, and writes each assembled instruction into instruction RAM at consecutive addresses. While loading, it holds the processor in reset; it releases the processor once the last word is written.

## Interface
Parameters:
- `BASE_ADDR`, 16'h0000: address of the first written word.
- `TIMEOUT`, 50_000_000: maximum idle cycles allowed between accepted bytes during a transfer.

Ports:
- `clk` input 1: system clock. One clock domain.
- `Reset` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle pulse that begins a load.
- `byte_in` input 8: incoming byte.
- `byte_valid` input 1: `byte_in` is valid.
- `byte_ready` output 1: loader can accept a byte.
- `mem_we` output 1: instruction RAM write strobe, one cycle wide.
- `mem_addr` output 16: instruction RAM write address.
- `mem_data` output 32: instruction RAM write data.
- `cpu_hold` output 1: holds the processor in reset (active-high) while high.
- `done` output 1: load completed successfully.
- `error` output 1: load aborted on timeout.

## Operation
- Frame format:
  - Byte 0: count[15:8]. Byte 1: count[7:0].
  - Then count×4 bytes, each instruction MSB first.
  - The first data byte goes to `mem_data[31:24]`.
- A byte is accepted only in a cycle where `byte_valid && byte_ready`.
- States:
  - IDLE: `cpu_hold`=0, `byte_ready`=0. `start` → LEN_HI.
  - LEN_HI: `byte_ready`=1. Accept → latch count[15:8], go to LEN_LO.
  - LEN_LO: `byte_ready`=1. Accept → latch count[7:0]. If count==0 go to DONE, else go to DATA with `mem_addr`=`BASE_ADDR`, byte index=0.
  - DATA: `byte_ready`=1. Each accept shifts the byte into the 32-bit assembler and increments the byte index (0..3). The accept at index 3 → WRITE.
  - WRITE: `byte_ready`=0, `mem_we`=1 for exactly one cycle. Then the word counter increments; if words==count go to DONE, else go to DATA with `mem_addr`+1.
  - DONE: `done`=1, `cpu_hold`=0. `start` → LEN_HI and clears `done`.
  - ERR: `error`=1, `cpu_hold`=1 (the program is invalid). `start` → LEN_HI and clears `error`.
- `cpu_hold`=1 in LEN_HI, LEN_LO, DATA, WRITE and ERR.
- Timeout:
  - A cycle counter clears on every accepted byte and on entry to LEN_HI.
  - It counts in LEN_HI, LEN_LO and DATA.
  - Reaching `TIMEOUT`-1 with no accept → ERR.
- `start` is ignored in LEN_HI, LEN_LO, DATA and WRITE.
- `mem_addr` is 16-bit and wraps from FFFF to 0000. The word count is 16-bit unsigned, maximum 65535 words.
- `byte_valid` while `byte_ready`=0 is ignored. The byte is not consumed; the source holds it.

## Timing
- Reset values: IDLE state; `byte_ready`=0, `mem_we`=0, `mem_addr`=`BASE_ADDR`, `mem_data`=0, `cpu_hold`=0, `done`=0, `error`=0; all counters 0.
- `Reset` asserted mid-load returns the block to IDLE immediately (asynchronous). A partially written memory is not cleaned.
- `mem_we` asserts in the cycle after the 4th byte of a word is accepted. `mem_addr` and `mem_data` are stable during that cycle.
- `done` rises in the cycle after the final WRITE cycle, or the cycle after the LEN_LO accept when count==0. `cpu_hold` falls in that same cycle.
- Maximum throughput: 4 bytes per 5 cycles.
- All outputs are registered.
- `start` and an accept in the same cycle in DONE/ERR: `start` takes effect; the byte is not accepted because `byte_ready`=0 there.

## Structure
- Shared package `loader_pkg`:
  - state enum (IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR);
  - byte-per-word constant (4);
  - default `TIMEOUT`.
- One sub-module, `loader_timer`:
  - inputs: `clk`, `Reset`, clear, enable;
  - output: expired;
  - parameterised by `TIMEOUT`.
- The top-level FSM, byte assembler and address/word counters live in `prog_loader`.

## Test plan
- Basic load: `start`, then bytes 00 02, 12 34 56 78, 9A BC DE F0 → writes 0000←12345678 and 0001←9ABCDEF0. `done`=1; `cpu_hold` falls one cycle after the 2nd write.
- Zero count: `start`, then 00 00 → no `mem_we`. `done`=1 the cycle after the 2nd byte.
- Backpressure: `byte_valid` held high continuously → exactly one `byte_ready`-low cycle per word. No byte is dropped or duplicated.
- Timeout: with `TIMEOUT`=16, send 00 01 AB, then stall 16 cycles → `error`=1, `cpu_hold`=1, no write. A following `start` plus a valid frame then completes.
- Reset mid-load: drop `Reset` after 5 data bytes → all outputs at reset values at once. A new `start` plus a frame writes from `BASE_ADDR`.
- Wrap: with `BASE_ADDR`=FFFF and count 2 → writes land at FFFF then 0000.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// No logic here; imported by prog_loader and loader_timer.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam int BYTES_PER_WORD  = 4;
  localparam int DEFAULT_TIMEOUT = 50_000_000;

endpackage

// File: rtl/loader_timer.sv
// Idle-cycle watchdog: counts while enabled, flags expiry at TIMEOUT-1.
// Latency: expired follows the count register combinationally; no backpressure.
module loader_timer
  import loader_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  assign expired = enable && (cnt == W'(TIMEOUT - 1));

  // Holds at the terminal value; the FSM leaves the counting states on expiry.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Frames a byte stream as [count][32-bit words MSB first] and writes instruction RAM.
// Latency: write one cycle after the 4th byte; byte_ready drops for that WRITE cycle (4 bytes / 5 cycles).
module prog_loader
  import loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  state_t      state;
  logic [15:0] count;
  logic [15:0] words;
  logic [1:0]  idx;
  logic        accept;
  logic        start_ok;
  logic        tmr_clear;
  logic        tmr_en;
  logic        expired;

  assign accept    = byte_valid && byte_ready;
  assign start_ok  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign tmr_clear = accept || start_ok;
  assign tmr_en    = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);

  loader_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .Reset  (Reset),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_data   <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      count      <= '0;
      words      <= '0;
      idx        <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= LEN_HI;
            byte_ready <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
          end
        end
        LEN_HI: begin
          if (accept) begin
            count[15:8] <= byte_in;
            state       <= LEN_LO;
          end else if (expired) begin
            state      <= ERR;
            byte_ready <= 1'b0;
            error      <= 1'b1;
          end
        end
        LEN_LO: begin
          if (accept) begin
            count[7:0] <= byte_in;
            if ({count[15:8], byte_in} == 16'd0) begin
              state      <= DONE;
              byte_ready <= 1'b0;
              cpu_hold   <= 1'b0;
              done       <= 1'b1;
            end else begin
              state    <= DATA;
              mem_addr <= BASE_ADDR;
              idx      <= '0;
              words    <= '0;
            end
          end else if (expired) begin
            state      <= ERR;
            byte_ready <= 1'b0;
            error      <= 1'b1;
          end
        end
        DATA: begin
          // mem_data doubles as the assembler; mem_we is low while it shifts.
          if (accept) begin
            mem_data <= {mem_data[23:0], byte_in};
            idx      <= idx + 2'd1;
            if (idx == 2'(BYTES_PER_WORD - 1)) begin
              state      <= WRITE;
              byte_ready <= 1'b0;
              mem_we     <= 1'b1;
            end
          end else if (expired) begin
            state      <= ERR;
            byte_ready <= 1'b0;
            error      <= 1'b1;
          end
        end
        WRITE: begin
          words <= words + 16'd1;
          if ((words + 16'd1) == count) begin
            state    <= DONE;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end else begin
            state      <= DATA;
            byte_ready <= 1'b1;
            mem_addr   <= mem_addr + 16'd1;
          end
        end
        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          cpu_hold   <= 1'b0;
        end
      endcase
    end
  end

endmodule
